regbank_wb_arbiter: RTL and testbench
=====================================

REGBANK_WB_ARBITER -- requirements
Module: regbank_wb_arbiter

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter REG_COUNT, default 16, number of registers; address width AW = $clog2(REG_COUNT).
REQ-003 SHALL have parameter N_REQ, default 4, number of writeback requesters (2..8).
REQ-004 SHALL use a single clock, clk; reset is rst, synchronous and active-high.
REQ-005 SHALL have ports clk  in  1  clock; rst  in  1  sync active-high reset.
REQ-006 SHALL have ports req_valid  in  N_REQ  per-requester write request; req_ready  out  N_REQ  per-requester grant.
REQ-007 SHALL have ports req_addr  in  N_REQ x AW  destination register; req_data  in  N_REQ x REG_WIDTH  write data.
REQ-008 SHALL have ports rsv_valid  in  1  issue-stage reservation request; rsv_addr  in  AW  register to reserve; rsv_ready  out  1  reservation accepted.
REQ-009 SHALL have ports we  out  1,  waddr  out  AW,  wdata  out  REG_WIDTH  register bank write port, driven as the CPU side of the bank interface.
REQ-010 SHALL have port busy  out  REG_COUNT  pending-write scoreboard, one bit per register.

Function
REQ-011 SHALL grant at most one requester per cycle; req_ready[i] is combinational, high only for the winner, and only when req_valid[i]=1.
REQ-012 SHALL transfer on req_valid[i] && req_ready[i]; requester holds addr/data stable until transfer.
REQ-013 SHALL arbitrate round-robin: search starts at pointer ptr, moving upward modulo N_REQ; first valid index wins.
REQ-014 SHALL update ptr to (winner+1) mod N_REQ after a grant; ptr is unchanged in cycles with no grant.
REQ-015 SHALL register the granted request: we=1, waddr, wdata appear exactly 1 cycle after the transfer cycle; we=0 otherwise.
REQ-016 SHALL sustain one write per cycle (back-to-back grants produce consecutive we=1 cycles).
REQ-017 SHALL hold waddr/wdata at their last values when we=0.
REQ-018 SHALL set rsv_ready = !busy[rsv_addr] (combinational); a reservation takes effect on rsv_valid && rsv_ready.
REQ-019 SHALL set busy[rsv_addr] at the edge ending an accepted reservation cycle.
REQ-020 SHALL clear busy[waddr] at the edge ending each cycle with we=1.
REQ-021 SHALL, on set and clear of the same address at the same edge, leave the bit set (set wins).
REQ-022 SHALL accept writes to non-busy registers (busy bit stays 0); no error is flagged.
REQ-023 SHALL allow a reservation to a different register in the same cycle as a write commit.

Reset
REQ-024 SHALL, while rst=1 at a clock edge, force we=0, waddr=0, wdata=0, busy=0, ptr=0.
REQ-025 SHALL hold req_ready=0 and rsv_ready=0 in any cycle where rst=1.
REQ-026 SHALL drop a request transferred in the cycle before reset; it never reaches we.

Structure
REQ-027 SHALL place default REG_WIDTH, REG_COUNT and N_REQ constants and a writeback request struct (addr, data) in shared package regbank_pkg.
REQ-028 SHALL implement arbitration in one sub-module rr_arbiter (valid vector in, one-hot grant out, registered pointer), with the write stage and scoreboard in the top.

Verification
REQ-029 SHALL cover reset: rst=1 for 2 cycles with all req_valid=1 -> req_ready=0, we=0, busy=0; first grant after release goes to requester 0.
REQ-030 SHALL cover round-robin: req_valid=4'b1111 held 8 cycles -> grants 0,1,2,3,0,1,2,3 and we=1 on 8 consecutive cycles, each 1 cycle late.
REQ-031 SHALL cover the skip case: ptr=1 and req_valid=4'b1001 -> requester 3 granted, then requester 0 on the next cycle.
REQ-032 SHALL cover the scoreboard: reserve r5, then req 2 writes r5=0xDEADBEEF -> busy[5]=1 until the edge after the we=1 cycle with waddr=5 and wdata=0xDEADBEEF.
REQ-033 SHALL cover the blocked reservation: busy[7]=1 with rsv_addr=7 -> rsv_ready=0; after commit to r7, rsv_ready=1 the next cycle.
REQ-034 SHALL cover reset mid-operation: a transfer in cycle t, then rst=1 in cycle t+1 -> we=0 in t+1 and busy all zero afterwards.

Source files
------------

// File: rtl/regbank_pkg.sv
// regbank_pkg
// Shared definitions for the register-bank writeback arbiter slice.
// The default bank geometry and requester count live here. The writeback
// request record, which pairs a destination register with its data, is
// sized for that default geometry.
package regbank_pkg;

  localparam int DEFAULT_REG_WIDTH = 32;
  localparam int DEFAULT_REG_COUNT = 16;
  localparam int DEFAULT_N_REQ     = 4;
  localparam int DEFAULT_AW        = $clog2(DEFAULT_REG_COUNT);

  // One writeback request: destination register and the value to write.
  typedef struct packed {
    logic [DEFAULT_AW-1:0]        addr;
    logic [DEFAULT_REG_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// This is a round-robin arbiter with a registered priority pointer.
// The search for a winner starts at the pointer and moves upward modulo
// N_REQ. The first valid index wins. After a grant, the pointer moves to
// the slot just past the winner. In cycles with no grant, the pointer
// keeps its value.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset (also masks the grant)
//   valid_i  in   N_REQ request vector
//   grant_o  out  N_REQ one-hot grant (all zero when nothing is granted)
module rr_arbiter
  import regbank_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] valid_i,
  output logic [N_REQ-1:0] grant_o
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Scan from the pointer upward with wraparound. The found flag holds
  // the first hit, so the grant stays one-hot. Reset forces no grant, so
  // nothing transfers while the bank is being cleared.
  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % N_REQ);
      if (!found && valid_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        ptr_d        = PW'((int'(idx) + 1) % N_REQ);
      end
    end
    if (rst) begin
      grant_o = '0;
      ptr_d   = ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regbank_wb_arbiter.sv
// regbank_wb_arbiter
// This block sits in front of the register-bank write port. Several
// writeback requesters compete through a round-robin arbiter. The winning
// request is registered and drives the bank one cycle later.
// A pending-write scoreboard holds one busy bit per register:
//   - The issue stage sets a register's bit when it reserves that register.
//   - The bit clears when the write to that register commits.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_valid / req_ready      per-requester handshake (ready = grant)
//   req_addr / req_data        per-requester destination and data
//   rsv_valid/rsv_addr/ready   issue-stage reservation handshake
//   we / waddr / wdata         bank write port
//   busy                       pending-write scoreboard
module regbank_wb_arbiter
  import regbank_pkg::*;
#(
  parameter int REG_WIDTH = DEFAULT_REG_WIDTH,
  parameter int REG_COUNT = DEFAULT_REG_COUNT,
  parameter int N_REQ     = DEFAULT_N_REQ,
  localparam int AW       = $clog2(REG_COUNT)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_REQ-1:0]                req_valid,
  output logic [N_REQ-1:0]                req_ready,
  input  logic [N_REQ-1:0][AW-1:0]        req_addr,
  input  logic [N_REQ-1:0][REG_WIDTH-1:0] req_data,
  input  logic                            rsv_valid,
  input  logic [AW-1:0]                   rsv_addr,
  output logic                            rsv_ready,
  output logic                            we,
  output logic [AW-1:0]                   waddr,
  output logic [REG_WIDTH-1:0]            wdata,
  output logic [REG_COUNT-1:0]            busy
);

  logic [N_REQ-1:0]     grant;
  logic                 xfer;
  logic [AW-1:0]        sel_addr;
  logic [REG_WIDTH-1:0] sel_data;
  logic                 we_q;
  logic [AW-1:0]        waddr_q;
  logic [REG_WIDTH-1:0] wdata_q;
  logic [REG_COUNT-1:0] busy_q;
  logic [REG_COUNT-1:0] busy_d;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid_i (req_valid),
    .grant_o (grant)
  );

  // The grant is one-hot, so OR-ing the masked lanes selects the winner.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = sel_addr | req_addr[i];
        sel_data = sel_data | req_data[i];
      end
    end
  end

  assign xfer      = |grant;
  assign req_ready = grant;
  assign rsv_ready = !rst && !busy_q[rsv_addr];

  // The commit clear is applied first and the reservation set second.
  // A reservation that lands on the register being committed therefore
  // stays pending.
  always_comb begin
    busy_d = busy_q;
    if (we_q) busy_d[waddr_q] = 1'b0;
    if (rsv_valid && rsv_ready) busy_d[rsv_addr] = 1'b1;
  end

  // Write stage. The address and data load only on a transfer, so they
  // hold their last values while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      we_q   <= xfer;
      busy_q <= busy_d;
      if (xfer) begin
        waddr_q <= sel_addr;
        wdata_q <= sel_data;
      end
    end
  end

  // Masking we with rst drops a write that was transferred in the cycle
  // just before reset.
  assign we    = we_q && !rst;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// tb_regbank_wb_arbiter
// Directed bench for regbank_wb_arbiter at its default geometry
// (32-bit data, 16 registers, 4 requesters).
// Timing of each step:
//   1. The bench waits for a rising edge plus 1 ns.
//   2. It drives the inputs.
//   3. It waits another 1 ns for combinational paths to settle.
//   4. It compares outputs with expected values worked out by hand.
module tb_regbank_wb_arbiter;
  import regbank_pkg::*;

  localparam int RW = 32;
  localparam int RC = 16;
  localparam int NR = 4;
  localparam int AW = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NR-1:0]            req_valid;
  logic [NR-1:0]            req_ready;
  logic [NR-1:0][AW-1:0]    req_addr;
  logic [NR-1:0][RW-1:0]    req_data;
  logic                     rsv_valid;
  logic [AW-1:0]            rsv_addr;
  logic                     rsv_ready;
  logic                     we;
  logic [AW-1:0]            waddr;
  logic [RW-1:0]            wdata;
  logic [RC-1:0]            busy;

  int checks   = 0;
  int failures = 0;

  regbank_wb_arbiter #(.REG_WIDTH(RW), .REG_COUNT(RC), .N_REQ(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_ready (rsv_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One directed sequence covering:
  //   - reset behaviour
  //   - round-robin order and pointer skipping
  //   - the scoreboard, blocked reservations and set-wins
  //   - reset in the middle of a transfer
  initial begin : applyStimulus
    wb_req_t r;
    rst       = 1'b1;
    req_valid = 4'b1111;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    for (int i = 0; i < NR; i++) begin
      r.addr      = AW'(i + 1);
      r.data      = 32'hA0 + i;
      req_addr[i] = r.addr;
      req_data[i] = r.data;
    end

    // Reset held for two edges with every requester asking.
    nextCycle();
    nextCycle();
    #1;
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_we", we, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rsv_ready", rsv_ready, 0);
    rst = 1'b0;
    #1;

    // All four requesters held valid for 8 cycles. Grants should rotate
    // 0,1,2,3,0,1,2,3, and each write appears one cycle after its grant.
    for (int c = 0; c < 8; c++) begin
      req_valid = 4'b1111;
      #1;
      checkOutput($sformatf("rr_grant_c%0d", c), req_ready, 64'(1) << (c % 4));
      if (c == 0) begin
        checkOutput("rr_we_c0", we, 0);
      end else begin
        checkOutput($sformatf("rr_we_c%0d", c), we, 1);
        checkOutput($sformatf("rr_waddr_c%0d", c), waddr, ((c - 1) % 4) + 1);
        checkOutput($sformatf("rr_wdata_c%0d", c), wdata, 32'hA0 + ((c - 1) % 4));
      end
      nextCycle();
    end
    req_valid = 4'b0000;
    #1;
    checkOutput("rr_we_last", we, 1);
    checkOutput("rr_waddr_last", waddr, 4);
    checkOutput("rr_idle_ready", req_ready, 0);
    nextCycle();
    checkOutput("idle_we", we, 0);
    checkOutput("idle_waddr_hold", waddr, 4);
    checkOutput("idle_wdata_hold", wdata, 32'hA3);
    checkOutput("rr_busy_still0", busy, 0);

    // Skip case: grant requester 0 so the pointer moves to 1. Then offer
    // 1001; requester 3 should win, then requester 0.
    req_valid = 4'b0001;
    #1;
    checkOutput("skip_pre_grant", req_ready, 4'b0001);
    nextCycle();
    req_valid = 4'b1001;
    #1;
    checkOutput("skip_grant3", req_ready, 4'b1000);
    nextCycle();
    checkOutput("skip_grant0", req_ready, 4'b0001);
    checkOutput("skip_waddr3", waddr, 4);
    nextCycle();
    req_valid = 4'b0000;
    #1;
    checkOutput("skip_waddr0", waddr, 1);
    nextCycle();

    // Scoreboard: reserve r5, then requester 2 writes 0xDEADBEEF to r5.
    rsv_valid = 1'b1;
    rsv_addr  = 4'd5;
    #1;
    checkOutput("sb_rsv_ready", rsv_ready, 1);
    checkOutput("sb_we_idle", we, 0);
    nextCycle();
    rsv_valid   = 1'b0;
    req_valid   = 4'b0100;
    req_addr[2] = 4'd5;
    req_data[2] = 32'hDEADBEEF;
    #1;
    checkOutput("sb_busy5_set", busy, 16'h0020);
    checkOutput("sb_grant2", req_ready, 4'b0100);
    nextCycle();
    req_valid = 4'b0000;
    #1;
    checkOutput("sb_we", we, 1);
    checkOutput("sb_waddr", waddr, 5);
    checkOutput("sb_wdata", wdata, 32'hDEADBEEF);
    checkOutput("sb_busy5_during", busy, 16'h0020);
    nextCycle();
    checkOutput("sb_we_after", we, 0);
    checkOutput("sb_busy5_clear", busy, 0);

    // Blocked reservation on r7 until the commit to r7 clears it.
    rsv_valid = 1'b1;
    rsv_addr  = 4'd7;
    #1;
    checkOutput("blk_first_rsv", rsv_ready, 1);
    nextCycle();
    checkOutput("blk_busy7", busy, 16'h0080);
    checkOutput("blk_rsv_ready0", rsv_ready, 0);
    req_valid   = 4'b0010;
    req_addr[1] = 4'd7;
    req_data[1] = 32'h77;
    #1;
    checkOutput("blk_grant1", req_ready, 4'b0010);
    nextCycle();
    req_valid = 4'b0000;
    #1;
    checkOutput("blk_we", we, 1);
    checkOutput("blk_waddr", waddr, 7);
    checkOutput("blk_rsv_still0", rsv_ready, 0);
    nextCycle();
    checkOutput("blk_busy_clear", busy, 0);
    checkOutput("blk_rsv_ready1", rsv_ready, 1);
    rsv_valid = 1'b0;
    #1;

    // Write to the non-busy r6. During its commit cycle, reserve r6;
    // the set should win over the clear.
    req_valid   = 4'b1000;
    req_addr[3] = 4'd6;
    req_data[3] = 32'h66;
    #1;
    checkOutput("sw_grant3", req_ready, 4'b1000);
    nextCycle();
    req_valid = 4'b0000;
    rsv_valid = 1'b1;
    rsv_addr  = 4'd6;
    #1;
    checkOutput("sw_we", we, 1);
    checkOutput("sw_rsv_ready", rsv_ready, 1);
    nextCycle();
    rsv_valid = 1'b0;
    #1;
    checkOutput("sw_busy6_set_wins", busy, 16'h0040);

    // Commit r6 while reserving a different register, r2, in the same cycle.
    req_valid = 4'b1000;
    #1;
    nextCycle();
    req_valid = 4'b0000;
    rsv_valid = 1'b1;
    rsv_addr  = 4'd2;
    #1;
    checkOutput("diff_we", we, 1);
    checkOutput("diff_waddr", waddr, 6);
    nextCycle();
    rsv_valid = 1'b0;
    #1;
    checkOutput("diff_busy", busy, 16'h0004);

    // Reset mid-operation: a transfer and a reservation in cycle t,
    // then rst in cycle t+1.
    req_valid   = 4'b0001;
    req_addr[0] = 4'd9;
    req_data[0] = 32'h99;
    rsv_valid   = 1'b1;
    rsv_addr    = 4'd9;
    #1;
    checkOutput("mid_grant0", req_ready, 4'b0001);
    checkOutput("mid_rsv_ready", rsv_ready, 1);
    nextCycle();
    rst       = 1'b1;
    req_valid = 4'b1111;
    rsv_addr  = 4'd3;
    #1;
    checkOutput("mid_we_dropped", we, 0);
    checkOutput("mid_busy_before", busy, 16'h0204);
    checkOutput("mid_req_ready0", req_ready, 0);
    checkOutput("mid_rsv_ready0", rsv_ready, 0);
    nextCycle();
    rst       = 1'b0;
    rsv_valid = 1'b0;
    #1;
    checkOutput("post_busy", busy, 0);
    checkOutput("post_we", we, 0);
    checkOutput("post_waddr", waddr, 0);
    checkOutput("post_wdata", wdata, 0);
    checkOutput("post_first_grant0", req_ready, 4'b0001);
    nextCycle();
    req_valid = 4'b0000;
    #1;
    checkOutput("post_we1", we, 1);
    checkOutput("post_waddr9", waddr, 9);
    checkOutput("post_wdata99", wdata, 32'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
